// File: rtl/time_keeper.sv
// Alarm-clock time keeper: turns minute/hour pulses into a 24-hour time of day,
// holds a settable alarm time and drives the ringing flag with a minute-based timeout.
module time_keeper #(
    parameter int USE_HOUR_PULSE   = 1,
    parameter int ALARM_RESET_HOUR = 6,
    parameter int ALARM_RESET_MIN  = 0,
    parameter int RING_MINUTES     = 5
) (
    input  logic       clk5MHz,
    input  logic       reset,
    input  logic       pulse1min,
    input  logic       pulse1hour,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       alarm_enable,
    input  logic       alarm_off,
    output logic [4:0] cur_hour,
    output logic [5:0] cur_min,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       alarm_ringing
);
    localparam int I_MIN   = 0;
    localparam int I_HOUR  = 1;
    localparam int I_STIME = 2;
    localparam int I_SALRM = 3;
    localparam int I_IMIN  = 4;
    localparam int I_IHOUR = 5;
    localparam int I_AEN   = 6;
    localparam int I_AOFF  = 7;

    localparam logic [4:0] RST_AHOUR  = 5'(ALARM_RESET_HOUR);
    localparam logic [5:0] RST_AMIN   = 6'(ALARM_RESET_MIN);
    localparam logic [5:0] RING_LIMIT = 6'(RING_MINUTES);

    logic [7:0] w_in;
    logic [7:0] r_sync1, r_sync2, r_prev;
    logic [7:0] w_rise;

    logic [4:0] r_cur_hour, r_alarm_hour, w_hour_next, w_ahour_next;
    logic [5:0] r_cur_min, r_alarm_min, w_min_next, w_amin_next;
    logic [5:0] r_ring_cnt;
    logic       r_ring, r_match_pend;

    logic w_mode_time, w_mode_alarm, w_en;
    logic w_min_tick, w_hour_tick, w_time_tick;
    logic w_match, w_ring_stop;

    function automatic logic [5:0] min_wrap(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] hour_wrap(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    assign w_in = {alarm_off, alarm_enable, inc_hour, inc_min,
                   set_alarm, set_time, pulse1hour, pulse1min};

    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise       = r_sync2 & ~r_prev;
    assign w_mode_time  = r_sync2[I_STIME];
    assign w_mode_alarm = r_sync2[I_SALRM] & ~r_sync2[I_STIME];
    assign w_en         = r_sync2[I_AEN];
    assign w_min_tick   = w_rise[I_MIN] & ~w_mode_time;

    // Hours either follow the external hour pulse or carry out of minute 59.
    generate
        if (USE_HOUR_PULSE != 0) begin : g_hour_pulse
            assign w_hour_tick = w_rise[I_HOUR] & ~w_mode_time;
        end else begin : g_hour_carry
            assign w_hour_tick = w_min_tick & (r_cur_min == 6'd59);
        end
    endgenerate

    assign w_time_tick = w_min_tick | w_hour_tick;

    always_comb begin
        w_min_next   = r_cur_min;
        w_hour_next  = r_cur_hour;
        w_amin_next  = r_alarm_min;
        w_ahour_next = r_alarm_hour;
        if (w_mode_time) begin
            if (w_rise[I_IMIN])  w_min_next  = min_wrap(r_cur_min);
            if (w_rise[I_IHOUR]) w_hour_next = hour_wrap(r_cur_hour);
        end else begin
            if (w_min_tick)  w_min_next  = min_wrap(r_cur_min);
            if (w_hour_tick) w_hour_next = hour_wrap(r_cur_hour);
            if (w_mode_alarm) begin
                if (w_rise[I_IMIN])  w_amin_next  = min_wrap(r_alarm_min);
                if (w_rise[I_IHOUR]) w_ahour_next = hour_wrap(r_alarm_hour);
            end
        end
    end

    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            r_cur_hour   <= '0;
            r_cur_min    <= '0;
            r_alarm_hour <= RST_AHOUR;
            r_alarm_min  <= RST_AMIN;
        end else begin
            r_cur_hour   <= w_hour_next;
            r_cur_min    <= w_min_next;
            r_alarm_hour <= w_ahour_next;
            r_alarm_min  <= w_amin_next;
        end
    end

    // Only a counting tick can arm the alarm; the match is registered so ringing
    // trails the time update by one cycle, and an alarm_off rise on either cycle vetoes it.
    assign w_match = w_time_tick & w_en & ~w_rise[I_AOFF]
                   & (w_hour_next == r_alarm_hour) & (w_min_next == r_alarm_min);
    assign w_ring_stop = w_rise[I_AOFF] | ~w_en | (r_ring_cnt == RING_LIMIT);

    always_ff @(posedge clk5MHz) begin
        if (reset) begin
            r_match_pend <= 1'b0;
            r_ring       <= 1'b0;
            r_ring_cnt   <= '0;
        end else begin
            r_match_pend <= w_match;
            if (r_ring) begin
                if (w_ring_stop) begin
                    r_ring     <= 1'b0;
                    r_ring_cnt <= '0;
                end else if (w_min_tick) begin
                    r_ring_cnt <= r_ring_cnt + 6'd1;
                end
            end else if (r_match_pend & w_en & ~w_rise[I_AOFF]) begin
                r_ring     <= 1'b1;
                r_ring_cnt <= '0;
            end
        end
    end

    assign cur_hour      = r_cur_hour;
    assign cur_min       = r_cur_min;
    assign alarm_hour    = r_alarm_hour;
    assign alarm_min     = r_alarm_min;
    assign alarm_ringing = r_ring;
endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: dut 0 carries hours from minutes, dut 1 uses the hour pulse.
module tb_time_keeper;
    localparam int MIN = 1, HOUR = 2, IMIN = 4, IHOUR = 8, AOFF = 16;

    typedef struct {
        int cyc;
        int h;
        int m;
        int ah;
        int am;
        int r;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] rst = 2'b11;
    logic [1:0] pmin = '0, phour = '0, st = '0, sa = '0;
    logic [1:0] imin = '0, ihour = '0, aen = '0, aoff = '0;
    logic [4:0] o_h [2];
    logic [5:0] o_m [2];
    logic [4:0] o_ah [2];
    logic [5:0] o_am [2];
    logic       o_r [2];

    exp_t q [2][$];
    int eh [2], em [2], eah [2], eam [2], er [2];
    int n_cmp = 0;
    int n_bad = 0;

    time_keeper #(.USE_HOUR_PULSE(0)) dut0 (
        .clk5MHz(clk), .reset(rst[0]), .pulse1min(pmin[0]), .pulse1hour(phour[0]),
        .set_time(st[0]), .set_alarm(sa[0]), .inc_min(imin[0]), .inc_hour(ihour[0]),
        .alarm_enable(aen[0]), .alarm_off(aoff[0]),
        .cur_hour(o_h[0]), .cur_min(o_m[0]), .alarm_hour(o_ah[0]), .alarm_min(o_am[0]),
        .alarm_ringing(o_r[0])
    );

    time_keeper #(.USE_HOUR_PULSE(1)) dut1 (
        .clk5MHz(clk), .reset(rst[1]), .pulse1min(pmin[1]), .pulse1hour(phour[1]),
        .set_time(st[1]), .set_alarm(sa[1]), .inc_min(imin[1]), .inc_hour(ihour[1]),
        .alarm_enable(aen[1]), .alarm_off(aoff[1]),
        .cur_hour(o_h[1]), .cur_min(o_m[1]), .alarm_hour(o_ah[1]), .alarm_min(o_am[1]),
        .alarm_ringing(o_r[1])
    );

    // Monitors: every visible change of a DUT's outputs must match the next queued expectation.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        logic [22:0] prev_snap;
        always @(negedge clk) begin
            logic [22:0] snap;
            exp_t e;
            snap = {o_h[gi], o_m[gi], o_ah[gi], o_am[gi], o_r[gi]};
            if (!rst[gi] && snap !== prev_snap) begin
                n_cmp++;
                if (q[gi].size() == 0) begin
                    n_bad++;
                    $display("FAIL mon%0d unexpected change: got %0d:%0d al %0d:%0d ring %0d @cyc %0d, want no change",
                             gi, o_h[gi], o_m[gi], o_ah[gi], o_am[gi], o_r[gi], cyc);
                end else begin
                    e = q[gi].pop_front();
                    if (e.cyc != cyc || int'(o_h[gi]) != e.h || int'(o_m[gi]) != e.m ||
                        int'(o_ah[gi]) != e.ah || int'(o_am[gi]) != e.am || int'(o_r[gi]) != e.r) begin
                        n_bad++;
                        $display("FAIL mon%0d: got %0d:%0d al %0d:%0d ring %0d @cyc %0d, want %0d:%0d al %0d:%0d ring %0d @cyc %0d",
                                 gi, o_h[gi], o_m[gi], o_ah[gi], o_am[gi], o_r[gi], cyc,
                                 e.h, e.m, e.ah, e.am, e.r, e.cyc);
                    end else begin
                        $display("ok mon%0d %0d:%0d al %0d:%0d ring %0d @cyc %0d",
                                 gi, e.h, e.m, e.ah, e.am, e.r, cyc);
                    end
                end
            end
            prev_snap = snap;
        end
    end

    function automatic void push(input int d, input int cy, input int h, input int m,
                                 input int ah, input int am, input int r);
        exp_t e;
        e.cyc = cy; e.h = h; e.m = m; e.ah = ah; e.am = am; e.r = r;
        q[d].push_back(e);
    endfunction

    task automatic drv(input int d, input int sig, input logic v);
        if ((sig & MIN)   != 0) pmin[d]  = v;
        if ((sig & HOUR)  != 0) phour[d] = v;
        if ((sig & IMIN)  != 0) imin[d]  = v;
        if ((sig & IHOUR) != 0) ihour[d] = v;
        if ((sig & AOFF)  != 0) aoff[d]  = v;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #2;
    endtask

    // Pulse inputs for 'hold' cycles; outputs expected 3 edges later, ringing state r4 one edge after that.
    task automatic ev(input int d, input int sig, input int hold, input int h, input int m,
                      input int ah, input int am, input int r3, input int r4);
        int c;
        c = cyc;
        drv(d, sig, 1'b1);
        if (h != eh[d] || m != em[d] || ah != eah[d] || am != eam[d] || r3 != er[d])
            push(d, c + 3, h, m, ah, am, r3);
        if (r4 != r3) push(d, c + 4, h, m, ah, am, r4);
        eh[d] = h; em[d] = m; eah[d] = ah; eam[d] = am; er[d] = r4;
        repeat (hold) @(posedge clk);
        #2;
        drv(d, sig, 1'b0);
        repeat (5) @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input int d, input string tag);
        n_cmp++;
        if (o_h[d] != 5'd0 || o_m[d] != 6'd0 || o_ah[d] != 5'd6 || o_am[d] != 6'd0 || o_r[d] != 1'b0) begin
            n_bad++;
            $display("FAIL %s: got %0d:%0d al %0d:%0d ring %0d, want 0:0 al 6:0 ring 0",
                     tag, o_h[d], o_m[d], o_ah[d], o_am[d], o_r[d]);
        end else begin
            $display("ok %s reset state", tag);
        end
    endtask

    task automatic reset_dut(input int d);
        rst[d] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst[d] = 1'b0;
        eh[d] = 0; em[d] = 0; eah[d] = 6; eam[d] = 0; er[d] = 0;
        settle();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            eh[d] = 0; em[d] = 0; eah[d] = 6; eam[d] = 0; er[d] = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 2'b00;
        settle();
        check_reset(0, "reset0");
        check_reset(1, "reset1");

        // Minute carry into hours
        for (int i = 0; i < 60; i++) ev(0, MIN, 1, (i == 59) ? 1 : 0, (i + 1) % 60, 6, 0, 0, 0);
        ev(0, MIN, 1000, 1, 1, 6, 0, 0, 0);
        ev(0, IMIN, 1, 1, 1, 6, 0, 0, 0);

        // Manual time set freezes counting
        reset_dut(0);
        st[0] = 1'b1; settle();
        for (int i = 1; i <= 3; i++) ev(0, IMIN, 1, 0, i, 6, 0, 0, 0);
        for (int i = 1; i <= 2; i++) ev(0, IHOUR, 1, i, 3, 6, 0, 0, 0);
        for (int i = 0; i < 5; i++) ev(0, MIN, 1, 2, 3, 6, 0, 0, 0);
        st[0] = 1'b0; settle();
        ev(0, MIN, 1, 2, 4, 6, 0, 0, 0);

        // Alarm start and timeout
        st[0] = 1'b1; settle();
        for (int i = 3; i <= 5; i++) ev(0, IHOUR, 1, i, 4, 6, 0, 0, 0);
        for (int i = 5; i <= 59; i++) ev(0, IMIN, 1, 5, i, 6, 0, 0, 0);
        st[0] = 1'b0; aen[0] = 1'b1; settle();
        ev(0, MIN, 1, 6, 0, 6, 0, 0, 1);
        for (int i = 1; i <= 4; i++) ev(0, MIN, 1, 6, i, 6, 0, 1, 1);
        ev(0, MIN, 1, 6, 5, 6, 0, 1, 0);

        // Alarm-set mode, then stop with alarm_off
        sa[0] = 1'b1; settle();
        for (int i = 1; i <= 6; i++) ev(0, IMIN, 1, 6, 5, 6, i, 0, 0);
        sa[0] = 1'b0; settle();
        ev(0, MIN, 1, 6, 6, 6, 6, 0, 1);
        ev(0, AOFF, 1, 6, 6, 6, 6, 0, 0);

        // alarm_off together with the start condition
        sa[0] = 1'b1; settle();
        ev(0, IMIN, 1, 6, 6, 6, 7, 0, 0);
        sa[0] = 1'b0; settle();
        ev(0, MIN | AOFF, 1, 6, 7, 6, 7, 0, 0);

        // Manual matches never ring
        sa[0] = 1'b1; settle();
        ev(0, IMIN, 1, 6, 7, 6, 8, 0, 0);
        sa[0] = 1'b0; st[0] = 1'b1; settle();
        ev(0, IMIN, 1, 6, 8, 6, 8, 0, 0);
        ev(0, IMIN, 1, 6, 9, 6, 8, 0, 0);
        st[0] = 1'b0; sa[0] = 1'b1; settle();
        ev(0, IMIN, 1, 6, 9, 6, 9, 0, 0);

        // Dropping alarm_enable stops ringing
        ev(0, IMIN, 1, 6, 9, 6, 10, 0, 0);
        sa[0] = 1'b0; settle();
        ev(0, MIN, 1, 6, 10, 6, 10, 0, 1);
        begin
            int c;
            c = cyc;
            aen[0] = 1'b0;
            push(0, c + 3, 6, 10, 6, 10, 0);
            er[0] = 0;
            settle();
        end
        aen[0] = 1'b1; settle();

        // Reset while ringing
        sa[0] = 1'b1; settle();
        ev(0, IMIN, 1, 6, 10, 6, 11, 0, 0);
        sa[0] = 1'b0; settle();
        ev(0, MIN, 1, 6, 11, 6, 11, 0, 1);
        rst[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset(0, "reset_mid_ring");
        @(posedge clk);
        #2;
        rst[0] = 1'b0;
        eh[0] = 0; em[0] = 0; eah[0] = 6; eam[0] = 0; er[0] = 0;
        settle();
        ev(0, MIN, 1, 0, 1, 6, 0, 0, 0);

        // Hour-pulse variant: 23:59 wraps
        st[1] = 1'b1; settle();
        for (int i = 1; i <= 23; i++) ev(1, IHOUR, 1, i, 0, 6, 0, 0, 0);
        for (int i = 1; i <= 59; i++) ev(1, IMIN, 1, 23, i, 6, 0, 0, 0);
        st[1] = 1'b0; settle();
        ev(1, MIN, 1, 23, 0, 6, 0, 0, 0);
        ev(1, HOUR, 1, 0, 0, 6, 0, 0, 0);
        st[1] = 1'b1; settle();
        for (int i = 1; i <= 23; i++) ev(1, IHOUR, 1, i, 0, 6, 0, 0, 0);
        for (int i = 1; i <= 59; i++) ev(1, IMIN, 1, 23, i, 6, 0, 0, 0);
        st[1] = 1'b0; settle();
        ev(1, MIN | HOUR, 1, 0, 0, 6, 0, 0, 0);
        ev(1, MIN, 1, 0, 1, 6, 0, 0, 0);

        repeat (10) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (q[d].size() != 0) begin
                n_bad++;
                $display("FAIL drain%0d: %0d expectations left, want 0", d, q[d].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
